// File: rtl/ctrl_pipe_hazard.sv
// Control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall detection,
// bubble insertion, branch flush and a saturating stall-event counter.

module ctrl_pipe_hazard_chk #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  pc_write_i,
    input  logic [REG_ADDR_W+6:0] ex_bundle_i
);

    // A stall always loads a bubble into EX, so it can never repeat on the next cycle.
    a_single_cycle_stall: assert property (@(posedge clk_i) disable iff (!rst_i)
        stall_i |=> !stall_i);

    // The cycle after a stall, EX holds an all-zero bundle.
    a_stall_bubble: assert property (@(posedge clk_i) disable iff (!rst_i)
        stall_i |=> (ex_bundle_i == '0));

    // PC enable is the exact complement of stall.
    a_pc_write: assert property (@(posedge clk_i) disable iff (!rst_i)
        pc_write_i == !stall_i);

endmodule

module ctrl_pipe_hazard #(
    parameter int STALL_CNT_W = 16,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic                   Branch_i,
    input  logic                   MemtoReg_i,
    input  logic [1:0]             ALUOp_i,
    input  logic                   MemWrite_i,
    input  logic                   ALUSrc_i,
    input  logic                   RegWrite_i,
    input  logic [REG_ADDR_W-1:0]  rs1_i,
    input  logic [REG_ADDR_W-1:0]  rs2_i,
    input  logic [REG_ADDR_W-1:0]  rd_i,
    input  logic                   flush_i,
    output logic [1:0]             ALUOp_o,
    output logic                   ALUSrc_o,
    output logic [REG_ADDR_W-1:0]  rd_ex_o,
    output logic                   Branch_o,
    output logic                   MemWrite_o,
    output logic                   MemRead_o,
    output logic [REG_ADDR_W-1:0]  rd_mem_o,
    output logic                   RegWrite_mem_o,
    output logic                   MemtoReg_o,
    output logic                   RegWrite_o,
    output logic [REG_ADDR_W-1:0]  rd_wb_o,
    output logic                   PCWrite_o,
    output logic                   IFIDWrite_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [REG_ADDR_W-1:0]  RD_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};

    // ID/EX stage registers
    logic                  ex_branch_q,   ex_branch_d;
    logic                  ex_memtoreg_q, ex_memtoreg_d;
    logic [1:0]            ex_aluop_q,    ex_aluop_d;
    logic                  ex_memwrite_q, ex_memwrite_d;
    logic                  ex_alusrc_q,   ex_alusrc_d;
    logic                  ex_regwrite_q, ex_regwrite_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,       ex_rd_d;

    // EX/MEM stage registers
    logic                  mem_branch_q,   mem_branch_d;
    logic                  mem_memtoreg_q, mem_memtoreg_d;
    logic                  mem_memwrite_q, mem_memwrite_d;
    logic                  mem_regwrite_q, mem_regwrite_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,       mem_rd_d;

    // MEM/WB stage registers
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,       wb_rd_d;

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard_s;
    logic stall_s;
    logic bubble_s;

    // Load-use detection against the instruction currently in EX; x0 is never a dependency.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_memtoreg_q && ex_regwrite_q && (ex_rd_q != RD_ZERO) && valid_i &&
            ((ex_rd_q == rs1_i) || (ex_rd_q == rs2_i))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        stall_s  = hazard_s && !flush_i;
        bubble_s = flush_i || stall_s || !valid_i;
    end

    // ID/EX next state: either the decoder bundle or an all-zero bubble.
    always_comb begin
        ex_branch_d   = 1'b0;
        ex_memtoreg_d = 1'b0;
        ex_aluop_d    = 2'b00;
        ex_memwrite_d = 1'b0;
        ex_alusrc_d   = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_rd_d       = RD_ZERO;
        if (bubble_s) begin
            ex_branch_d   = 1'b0;
            ex_memtoreg_d = 1'b0;
            ex_aluop_d    = 2'b00;
            ex_memwrite_d = 1'b0;
            ex_alusrc_d   = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_rd_d       = RD_ZERO;
        end else begin
            ex_branch_d   = Branch_i;
            ex_memtoreg_d = MemtoReg_i;
            ex_aluop_d    = ALUOp_i;
            ex_memwrite_d = MemWrite_i;
            ex_alusrc_d   = ALUSrc_i;
            ex_regwrite_d = RegWrite_i;
            ex_rd_d       = rd_i;
        end
    end

    // EX/MEM and MEM/WB next state: ALUOp/ALUSrc stop at EX, only WB controls reach WB.
    always_comb begin
        mem_branch_d   = ex_branch_q;
        mem_memtoreg_d = ex_memtoreg_q;
        mem_memwrite_d = ex_memwrite_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_rd_d       = ex_rd_q;
        wb_memtoreg_d  = mem_memtoreg_q;
        wb_regwrite_d  = mem_regwrite_q;
        wb_rd_d        = mem_rd_q;
    end

    // Stall-event counter, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stage registers and counter, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_branch_q    <= 1'b0;
            ex_memtoreg_q  <= 1'b0;
            ex_aluop_q     <= 2'b00;
            ex_memwrite_q  <= 1'b0;
            ex_alusrc_q    <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_rd_q        <= RD_ZERO;
            mem_branch_q   <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= RD_ZERO;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= RD_ZERO;
            stall_cnt_q    <= {STALL_CNT_W{1'b0}};
        end else begin
            ex_branch_q    <= ex_branch_d;
            ex_memtoreg_q  <= ex_memtoreg_d;
            ex_aluop_q     <= ex_aluop_d;
            ex_memwrite_q  <= ex_memwrite_d;
            ex_alusrc_q    <= ex_alusrc_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_rd_q        <= ex_rd_d;
            mem_branch_q   <= mem_branch_d;
            mem_memtoreg_q <= mem_memtoreg_d;
            mem_memwrite_q <= mem_memwrite_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_rd_q       <= mem_rd_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_rd_q        <= wb_rd_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ALUOp_o        = ex_aluop_q;
    assign ALUSrc_o       = ex_alusrc_q;
    assign rd_ex_o        = ex_rd_q;
    assign Branch_o       = mem_branch_q;
    assign MemWrite_o     = mem_memwrite_q;
    assign MemRead_o      = mem_memtoreg_q;
    assign rd_mem_o       = mem_rd_q;
    assign RegWrite_mem_o = mem_regwrite_q;
    assign MemtoReg_o     = wb_memtoreg_q;
    assign RegWrite_o     = wb_regwrite_q;
    assign rd_wb_o        = wb_rd_q;
    assign PCWrite_o      = !stall_s;
    assign IFIDWrite_o    = !stall_s;
    assign stall_cnt_o    = stall_cnt_q;

    ctrl_pipe_hazard_chk #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_s),
        .pc_write_i  (PCWrite_o),
        .ex_bundle_i ({ex_branch_q, ex_memtoreg_q, ex_aluop_q, ex_memwrite_q,
                       ex_alusrc_q, ex_regwrite_q, ex_rd_q})
    );

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed, table-driven bench for ctrl_pipe_hazard (counter width 2 to exercise saturation).

module tb_ctrl_pipe_hazard;

    typedef struct packed {
        logic       branch;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct {
        logic       valid;
        ctrl_t      c;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       flush;
        logic       exp_bubble;
        logic       exp_pcw;
        logic [1:0] exp_cnt;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i, Branch_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i, flush_i;
    logic [1:0] ALUOp_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic [1:0] ALUOp_o;
    logic       ALUSrc_o, Branch_o, MemWrite_o, MemRead_o, RegWrite_mem_o;
    logic       MemtoReg_o, RegWrite_o, PCWrite_o, IFIDWrite_o;
    logic [4:0] rd_ex_o, rd_mem_o, rd_wb_o;
    logic [1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    ctrl_t exp_ex, exp_mem, exp_wb;
    vec_t  vecs[25];

    ctrl_pipe_hazard #(.STALL_CNT_W(2), .REG_ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Branch_i(Branch_i),
        .MemtoReg_i(MemtoReg_i), .ALUOp_i(ALUOp_i), .MemWrite_i(MemWrite_i),
        .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rd_i(rd_i), .flush_i(flush_i), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .rd_ex_o(rd_ex_o), .Branch_o(Branch_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .rd_mem_o(rd_mem_o), .RegWrite_mem_o(RegWrite_mem_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .rd_wb_o(rd_wb_o),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t ctl(input logic b, input logic m2r, input logic [1:0] op,
                                  input logic mw, input logic as, input logic rw,
                                  input logic [4:0] rd);
        ctl = '{branch: b, memtoreg: m2r, aluop: op, memwrite: mw,
                alusrc: as, regwrite: rw, rd: rd};
    endfunction

    function automatic vec_t mkv(input logic v, input ctrl_t c, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic fl, input logic bub,
                                 input logic pcw, input logic [1:0] cnt);
        mkv = '{valid: v, c: c, rs1: r1, rs2: r2, flush: fl,
                exp_bubble: bub, exp_pcw: pcw, exp_cnt: cnt};
    endfunction

    task automatic drive(input logic v, input ctrl_t c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic fl);
        valid_i = v;  Branch_i = c.branch; MemtoReg_i = c.memtoreg; ALUOp_i = c.aluop;
        MemWrite_i = c.memwrite; ALUSrc_i = c.alusrc; RegWrite_i = c.regwrite;
        rd_i = c.rd; rs1_i = r1; rs2_i = r2; flush_i = fl;
    endtask

    task automatic chk_stages(input string tag);
        chk({tag, "_ex"},  {ALUOp_o, ALUSrc_o, rd_ex_o}, {exp_ex.aluop, exp_ex.alusrc, exp_ex.rd});
        chk({tag, "_mem"}, {Branch_o, MemWrite_o, MemRead_o, RegWrite_mem_o, rd_mem_o},
            {exp_mem.branch, exp_mem.memwrite, exp_mem.memtoreg, exp_mem.regwrite, exp_mem.rd});
        chk({tag, "_wb"},  {MemtoReg_o, RegWrite_o, rd_wb_o},
            {exp_wb.memtoreg, exp_wb.regwrite, exp_wb.rd});
    endtask

    initial begin
        ctrl_t ld5, ld7, ld0, ld9, add6, add6z, sw7, addi7, add8, add10, beq;
        ld5   = ctl(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5'd5);
        ld7   = ctl(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5'd7);
        ld0   = ctl(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5'd0);
        ld9   = ctl(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9);
        add6  = ctl(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd6);
        add6z = ctl(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd6);
        sw7   = ctl(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 5'd0);
        addi7 = ctl(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 5'd7);
        add8  = ctl(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd8);
        add10 = ctl(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd10);
        beq   = ctl(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);

        //              valid ctrl   rs1    rs2   flush bub  pcw  cnt
        vecs[0]  = mkv(1'b1, ld5,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd0);
        vecs[1]  = mkv(1'b1, add6,  5'd5,  5'd1, 1'b0, 1'b1, 1'b0, 2'd1);
        vecs[2]  = mkv(1'b1, add6,  5'd5,  5'd1, 1'b0, 1'b0, 1'b1, 2'd1);
        vecs[3]  = mkv(1'b1, ld7,   5'd2,  5'd0, 1'b0, 1'b0, 1'b1, 2'd1);
        vecs[4]  = mkv(1'b1, sw7,   5'd2,  5'd7, 1'b0, 1'b1, 1'b0, 2'd2);
        vecs[5]  = mkv(1'b1, sw7,   5'd2,  5'd7, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[6]  = mkv(1'b1, ld0,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[7]  = mkv(1'b1, add6z, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[8]  = mkv(1'b1, addi7, 5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[9]  = mkv(1'b1, add8,  5'd7,  5'd7, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[10] = mkv(1'b1, ld9,   5'd3,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[11] = mkv(1'b1, add10, 5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 2'd2);
        vecs[12] = mkv(1'b0, add6,  5'd9,  5'd1, 1'b0, 1'b1, 1'b1, 2'd2);
        vecs[13] = mkv(1'b1, ld5,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[14] = mkv(1'b0, add6,  5'd5,  5'd1, 1'b0, 1'b1, 1'b1, 2'd2);
        vecs[15] = mkv(1'b1, beq,   5'd1,  5'd2, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[16] = mkv(1'b1, ld5,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        vecs[17] = mkv(1'b1, add6,  5'd5,  5'd1, 1'b0, 1'b1, 1'b0, 2'd3);
        vecs[18] = mkv(1'b1, add6,  5'd5,  5'd1, 1'b0, 1'b0, 1'b1, 2'd3);
        vecs[19] = mkv(1'b1, ld5,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        vecs[20] = mkv(1'b1, add6,  5'd1,  5'd5, 1'b0, 1'b1, 1'b0, 2'd3);
        vecs[21] = mkv(1'b1, add6,  5'd1,  5'd5, 1'b0, 1'b0, 1'b1, 2'd3);
        vecs[22] = mkv(1'b1, ld5,   5'd1,  5'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        vecs[23] = mkv(1'b1, add6,  5'd5,  5'd5, 1'b0, 1'b1, 1'b0, 2'd3);
        vecs[24] = mkv(1'b1, add6,  5'd5,  5'd5, 1'b0, 1'b0, 1'b1, 2'd3);

        // Power-on reset
        rst_i = 1'b0;
        drive(1'b0, '0, 5'd0, 5'd0, 1'b0);
        exp_ex = '0; exp_mem = '0; exp_wb = '0;
        #1;
        chk_stages("reset");
        chk("reset_pcw", {PCWrite_o, IFIDWrite_o}, {1'b1, 1'b1});
        chk("reset_cnt", stall_cnt_o, 2'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            drive(vecs[i].valid, vecs[i].c, vecs[i].rs1, vecs[i].rs2, vecs[i].flush);
            #1;
            chk($sformatf("v%0d_pcw", i), {PCWrite_o, IFIDWrite_o},
                {vecs[i].exp_pcw, vecs[i].exp_pcw});
            @(posedge clk_i);
            #1;
            exp_wb  = exp_mem;
            exp_mem = exp_ex;
            exp_ex  = vecs[i].exp_bubble ? ctrl_t'(0) : vecs[i].c;
            chk_stages($sformatf("v%0d", i));
            chk($sformatf("v%0d_cnt", i), stall_cnt_o, vecs[i].exp_cnt);
        end

        // Reset asserted in the middle of a load-use stall
        @(negedge clk_i);
        drive(1'b1, ld5, 5'd1, 5'd0, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(1'b1, add6, 5'd5, 5'd1, 1'b0);
        #1;
        chk("midrst_stall", PCWrite_o, 1'b0);
        #1;
        rst_i = 1'b0;
        #1;
        exp_ex = '0; exp_mem = '0; exp_wb = '0;
        chk_stages("midrst");
        chk("midrst_cnt", stall_cnt_o, 2'd0);
        chk("midrst_pcw", {PCWrite_o, IFIDWrite_o}, {1'b1, 1'b1});
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("release_pcw", {PCWrite_o, IFIDWrite_o}, {1'b1, 1'b1});
        chk("release_cnt", stall_cnt_o, 2'd0);
        @(posedge clk_i);
        #1;
        chk("release_ex_rd", rd_ex_o, 5'd6);
        chk("release_cnt2", stall_cnt_o, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
